// File: rtl/debouncer_pkg.sv
// -----------------------------------------------------------------------------
// debouncer_pkg
// Shared types and helpers for the debouncer slice.
//   state_t      : the two qualification states of the debouncer
//   cnt_width()  : width of the stability counter for a given cycle count
//   DEFAULT_*    : default parameter values used by the top level
// -----------------------------------------------------------------------------
package debouncer_pkg;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_t;

    localparam int DEFAULT_SYNC_STAGES   = 2;
    localparam int DEFAULT_STABLE_CYCLES = 16;
    localparam bit DEFAULT_RESET_VALUE   = 1'b0;

    // The counter only ever reaches stable_cycles-1, but it is sized to hold
    // stable_cycles so the width stays at least one bit for stable_cycles == 1.
    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debouncer_if.sv
// -----------------------------------------------------------------------------
// debouncer_if
// Signal bundle between a raw input source and the debouncer.
//   i_signal  : raw asynchronous level (driven by the source)
//   o_signal  : debounced, registered level (driven by the debouncer)
//   o_pending : high while a candidate change is being qualified
// Modports:
//   master : the side that drives the raw input and observes the results
//   slave  : the debouncer itself
// -----------------------------------------------------------------------------
interface debouncer_if;

    logic i_signal;
    logic o_signal;
    logic o_pending;

    modport master (
        output i_signal,
        input  o_signal,
        input  o_pending
    );

    modport slave (
        input  i_signal,
        output o_signal,
        output o_pending
    );

endinterface

// File: rtl/debouncer_synchronizer.sv
// -----------------------------------------------------------------------------
// synchronizer
// Plain flop chain that brings an asynchronous level into the i_clk domain.
// Reused by other asynchronous-input blocks.
// Parameters:
//   p_STAGES      : number of flops in the chain (at least 2)
//   p_RESET_VALUE : value every flop takes while i_rst is high
// Ports:
//   i_clk    : clock
//   i_rst    : synchronous, active-high reset
//   i_signal : asynchronous input
//   o_signal : synchronised output (last flop of the chain)
// -----------------------------------------------------------------------------
module synchronizer #(
    parameter int p_STAGES      = 2,
    parameter bit p_RESET_VALUE = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_signal,
    output logic o_signal
);

    logic [p_STAGES-1:0] sync_q;

    // Straight shift chain with nothing between the flops, so metastability
    // in the first stage has a full cycle to resolve before it is used.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= {p_STAGES{p_RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[p_STAGES-2:0], i_signal};
        end
    end

    assign o_signal = sync_q[p_STAGES-1];

endmodule

// File: rtl/debouncer.sv
// -----------------------------------------------------------------------------
// debouncer
// Synchronises a raw, possibly bouncing input and outputs a clean level that
// only follows the input once the synchronised value has differed from the
// current output for p_STABLE_CYCLES consecutive cycles.
// Parameters:
//   p_SYNC_STAGES   : synchroniser depth (at least 2)
//   p_STABLE_CYCLES : consecutive mismatching cycles needed to flip (at least 1)
//   p_RESET_VALUE   : reset value of the synchroniser and the output
// Ports:
//   i_clk        : clock, all state changes on its rising edge
//   i_rst        : synchronous, active-high reset
//   bus.i_signal : raw asynchronous input
//   bus.o_signal : debounced, registered level
//   bus.o_pending: registered, high while a change is being qualified
// -----------------------------------------------------------------------------
module debouncer
    import debouncer_pkg::*;
#(
    parameter int p_SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int p_STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter bit p_RESET_VALUE   = DEFAULT_RESET_VALUE
) (
    input  logic         i_clk,
    input  logic         i_rst,
    debouncer_if.slave   bus
);

    localparam int              CNT_W    = cnt_width(p_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(p_STABLE_CYCLES - 1);

    logic             s;
    logic [CNT_W-1:0] cnt;
    logic             out_q;
    state_t           state;

    synchronizer #(
        .p_STAGES      (p_SYNC_STAGES),
        .p_RESET_VALUE (p_RESET_VALUE)
    ) u_sync (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_signal (bus.i_signal),
        .o_signal (s)
    );

    // Qualification: any return of s to the output value throws away all
    // accumulated credit. The flip happens on the edge where the counter
    // already holds p_STABLE_CYCLES-1, so with p_STABLE_CYCLES == 1 the very
    // first mismatching edge flips the output and SETTLING is never entered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_q <= p_RESET_VALUE;
            cnt   <= '0;
            state <= ST_STABLE;
        end else if (s == out_q) begin
            cnt   <= '0;
            state <= ST_STABLE;
        end else if (cnt == CNT_LAST) begin
            out_q <= s;
            cnt   <= '0;
            state <= ST_STABLE;
        end else begin
            cnt   <= cnt + CNT_W'(1);
            state <= ST_SETTLING;
        end
    end

    assign bus.o_signal  = out_q;
    assign bus.o_pending = (state == ST_SETTLING);

endmodule

// File: tb/tb_debouncer.sv
// -----------------------------------------------------------------------------
// tb_debouncer
// Self-checking bench for debouncer. Instance A uses 2 sync stages,
// 4 stable cycles, reset value 0; instance B uses 2 sync stages, 1 stable
// cycle, reset value 1. Each stimulus cycle pushes the outputs expected after
// the next rising edge onto a scoreboard; a monitor pops and compares them
// one time unit after that edge.
// -----------------------------------------------------------------------------
module tb_debouncer;

    typedef struct {
        string tag;
        int    idx;
        bit    which;
        logic  exp_o;
        logic  exp_p;
    } exp_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks;
    int   errors;
    exp_t sb[$];

    debouncer_if bus_a ();
    debouncer_if bus_b ();

    debouncer #(
        .p_SYNC_STAGES   (2),
        .p_STABLE_CYCLES (4),
        .p_RESET_VALUE   (1'b0)
    ) dut_a (
        .i_clk (clk),
        .i_rst (rst_a),
        .bus   (bus_a)
    );

    debouncer #(
        .p_SYNC_STAGES   (2),
        .p_STABLE_CYCLES (1),
        .p_RESET_VALUE   (1'b1)
    ) dut_b (
        .i_clk (clk),
        .i_rst (rst_b),
        .bus   (bus_b)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Drives one DUT from per-cycle character strings ('1' or '0'), one
    // character per rising edge, and queues what that edge should produce.
    task automatic applyStimulus(input string tag, input bit which,
                                 input string sig_s, input string rst_s,
                                 input string exp_o, input string exp_p);
        exp_t e;
        for (int i = 0; i < sig_s.len(); i++) begin
            @(negedge clk);
            if (which == 1'b0) begin
                bus_a.i_signal = (sig_s[i] == "1");
                rst_a          = (rst_s[i] == "1");
            end else begin
                bus_b.i_signal = (sig_s[i] == "1");
                rst_b          = (rst_s[i] == "1");
            end
            e.tag   = tag;
            e.idx   = i;
            e.which = which;
            e.exp_o = (exp_o[i] == "1");
            e.exp_p = (exp_p[i] == "1");
            sb.push_back(e);
        end
    endtask

    // Scoreboard monitor: samples away from the active edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.which == 1'b0) begin
                checkOutput($sformatf("%s[%0d].o_signal", e.tag, e.idx),
                            32'(bus_a.o_signal), 32'(e.exp_o));
                checkOutput($sformatf("%s[%0d].o_pending", e.tag, e.idx),
                            32'(bus_a.o_pending), 32'(e.exp_p));
            end else begin
                checkOutput($sformatf("%s[%0d].o_signal", e.tag, e.idx),
                            32'(bus_b.o_signal), 32'(e.exp_o));
                checkOutput($sformatf("%s[%0d].o_pending", e.tag, e.idx),
                            32'(bus_b.o_pending), 32'(e.exp_p));
            end
        end
    end

    initial begin
        checks         = 0;
        errors         = 0;
        rst_a          = 1'b1;
        rst_b          = 1'b1;
        bus_a.i_signal = 1'b1;
        bus_b.i_signal = 1'b1;

        // Instance A: reset held with the input high, output must stay low.
        applyStimulus("reset",       1'b0, "111",     "111",     "000",     "000");
        // Release with input still high: this is edge 0 of a clean rise.
        applyStimulus("clean_rise",  1'b0, "1111111", "0000000", "0000011", "0011100");
        applyStimulus("clean_fall",  1'b0, "0000000", "0000000", "1111100", "0011100");
        // Three-cycle pulse is one short of qualifying.
        applyStimulus("glitch",      1'b0, "1110000", "0000000", "0000000", "0011100");
        // Ten cycles of bounce, then a steady 1 first sampled on edge 10.
        applyStimulus("bounce",      1'b0, "10101010101111111", "00000000000000000",
                                           "00000000000000011", "00101010101011100");
        applyStimulus("bounce_fall", 1'b0, "0000000", "0000000", "1111100", "0011100");
        // Reset on edge 3 aborts qualification; full latency after release.
        applyStimulus("rst_mid",     1'b0, "1111111111", "0001000000",
                                           "0000000001", "0010001110");
        applyStimulus("rst_mid_fall",1'b0, "0000000", "0000000", "1111100", "0011100");

        // Instance B: one stable cycle, reset value 1, pending never rises.
        applyStimulus("b_reset",     1'b1, "11",   "11",   "11",   "00");
        applyStimulus("b_fall",      1'b1, "0000", "0000", "1100", "0000");
        applyStimulus("b_rise",      1'b1, "111",  "000",  "001",  "000");

        // Let the monitor consume the last entry, then confirm nothing is left.
        @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
